regfile_mp: RTL and testbench
=============================

// Module: regfile_mp
// PURPOSE
//   Parametrised multi-port register file with concurrent read and write ports.
//   Every enabled port is serviced in the same cycle; there is no priority starvation between ports.
//   Reads are registered (1-cycle latency) and carry a valid strobe.
//   Sits between the decode/issue stage (read addresses) and writeback (write ports) of the datapath.
// PARAMETERS
//   DATA_W    64                 width of each entry
//   DEPTH     32                 number of entries; need not be a power of two
//   ADDR_W    $clog2(DEPTH)      address width (derived; do not override)
//   NUM_RD    4                  number of read ports
//   NUM_WR    2                  number of write ports; lower index has higher priority
//   ZERO_REG  0                  1: entry 0 always reads 0 and writes to it are dropped
// PORTS
//   clk           in   1                clock; all logic on posedge
//   rst_n         in   1                synchronous reset, active-low
//   rd_en         in   NUM_RD           per-port read request
//   rd_addr       in   NUM_RD*ADDR_W    packed read addresses; port i at [i*ADDR_W +: ADDR_W]
//   rd_data       out  NUM_RD*DATA_W    packed registered read data
//   rd_valid      out  NUM_RD           rd_en delayed by one cycle
//   wr_en         in   NUM_WR           per-port write enable
//   wr_addr       in   NUM_WR*ADDR_W    packed write addresses
//   wr_data       in   NUM_WR*DATA_W    packed write data
//   wr_collision  out  1                registered; 1 if >=2 enabled write ports hit the same address last cycle
// BEHAVIOUR
//   Reset (rst_n=0 at posedge)
//     - All entries, rd_data, rd_valid and wr_collision clear to 0.
//     - Reset overrides every enable in that cycle; a request presented during reset is lost.
//     - Reset mid-read clears rd_valid on the next edge.
//   Write
//     - At posedge, each enabled port writes its entry.
//     - Same address on several enabled ports: lowest-index port wins.
//     - wr_collision=1 on the following cycle only (one pulse per colliding cycle).
//   Read
//     - rd_en[i] at edge N -> rd_data[i] and rd_valid[i]=1 after edge N.
//     - With rd_en[i]=0, rd_data[i] holds its last value and rd_valid[i]=0.
//     - Multiple ports may read the same address.
//   Read/write same address, same edge: see CONFIGURATION.
//   Out-of-range address (addr >= DEPTH)
//     - Write is dropped and is not counted as a collision.
//     - Read returns 0 with rd_valid=1.
//   ZERO_REG=1: addr 0 reads 0; writes to addr 0 are dropped (no collision flagged).
//   Width rules: no arithmetic; data is stored and returned bit-exact.
// CONFIGURATION
//   REGFILE_BYPASS_EN defined
//     - A read colliding with a write on the same edge returns the new data, i.e. the winning write port's data.
//     - ZERO_REG and out-of-range rules still apply.
//   REGFILE_BYPASS_EN undefined
//     - Such a read returns the pre-write contents.
//     - The new value is visible to reads issued on the next edge.
// STRUCTURE
//   Package regfile_pkg
//     - Default DATA_W, DEPTH, NUM_RD, NUM_WR.
//     - Function clog2 for address width.
//     - Packed-slice helper macros/functions for the port buses.
//   Sub-module regfile_wr_sel (combinational, one instance)
//     - Inputs: wr_en/wr_addr/wr_data.
//     - Outputs: per-entry write strobe, winning data and collision flag.
//     - Reused by the bypass path to find the winning write for a read address.
//   Top level holds the storage array, read registers, rd_valid and wr_collision flops.
// TESTING
//   1) Reset: rst_n=0 for 2 cycles, then read all 32 entries -> every rd_data=0, rd_valid only after rd_en.
//   2) Concurrent: write port0 addr3=0xA5A5, port1 addr7=0x1234; next cycle read 3 and 7 on ports 0..3
//      -> 0xA5A5/0x1234 one cycle later.
//   3) Collision: port0 and port1 both write addr 5 (0x11, 0x22) -> entry5=0x11, wr_collision=1 for one cycle.
//   4) RAW same edge: entry9=0xFF, write 9<-0x77 while reading 9
//      -> 0x77 with REGFILE_BYPASS_EN, 0xFF without; next read 0x77 in both builds.
//   5) ZERO_REG=1, DEPTH=20: write addr0=0xDEAD and addr25=0xBEEF
//      -> reads of 0 and 25 return 0, wr_collision stays 0.
//   6) Reset mid-op: assert rst_n=0 with wr_en=2'b11, rd_en=4'hF -> no write lands, rd_valid=0, entries 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the multi-port register file.
// Optional feature macro: REGFILE_BYPASS_EN (same-edge write-to-read forwarding).
`ifndef REGFILE_PKG_SV
`define REGFILE_PKG_SV

// Slice port i of a flat packed bus whose fields are w bits wide.
`define RF_SLICE(bus, i, w) bus[(i)*(w) +: (w)]

package regfile_pkg;

   localparam int DEF_DATA_W = 64;
   localparam int DEF_DEPTH  = 32;
   localparam int DEF_NUM_RD = 4;
   localparam int DEF_NUM_WR = 2;

   // Address width for n entries; never below 1 so a 1-entry file still has a port.
   function automatic int clog2(input int n);
      int r;
      r = 1;
      for (int i = 1; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

endpackage

`endif

// File: rtl/regfile_mp_if.sv
// Port bundle of the register file: issue-side reads, writeback-side writes.
// Optional feature macro: REGFILE_BYPASS_EN (affects the consumer only).
interface regfile_mp_if
   import regfile_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = DEF_DEPTH,
   parameter int NUM_RD = DEF_NUM_RD,
   parameter int NUM_WR = DEF_NUM_WR
);
   localparam int ADDR_W = clog2(DEPTH);

   logic [NUM_RD-1:0]        rd_en;
   logic [NUM_RD*ADDR_W-1:0] rd_addr;
   logic [NUM_RD*DATA_W-1:0] rd_data;
   logic [NUM_RD-1:0]        rd_valid;
   logic [NUM_WR-1:0]        wr_en;
   logic [NUM_WR*ADDR_W-1:0] wr_addr;
   logic [NUM_WR*DATA_W-1:0] wr_data;
   logic                     wr_collision;

   modport master (
      output rd_en, rd_addr, wr_en, wr_addr, wr_data,
      input  rd_data, rd_valid, wr_collision
   );

   modport slave (
      input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
      output rd_data, rd_valid, wr_collision
   );

endinterface

// File: rtl/regfile_wr_sel.sv
// Write-port arbitration: per-entry strobe and winning data, plus collision detect.
// The per-entry outputs also serve the read-bypass path (REGFILE_BYPASS_EN).
module regfile_wr_sel
   import regfile_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int DEPTH    = DEF_DEPTH,
   parameter int ADDR_W   = clog2(DEPTH),
   parameter int NUM_WR   = DEF_NUM_WR,
   parameter int ZERO_REG = 0
) (
   input  logic [NUM_WR-1:0]             wr_en,
   input  logic [NUM_WR*ADDR_W-1:0]      wr_addr,
   input  logic [NUM_WR*DATA_W-1:0]      wr_data,
   output logic [DEPTH-1:0]              wr_stb,
   output logic [DEPTH-1:0][DATA_W-1:0]  wr_win,
   output logic                          collision
);

   // A write is real only if it lands in range and not on a hardwired zero entry.
   function automatic logic legal(input logic [ADDR_W-1:0] a);
      return (int'(a) < DEPTH) && !((ZERO_REG != 0) && (a == '0));
   endfunction

   // Per entry: scan ports high to low so the lowest-index port overwrites last and wins.
   always_comb begin
      wr_stb = '0;
      wr_win = '0;
      for (int e = 0; e < DEPTH; e++) begin
         if (!((ZERO_REG != 0) && (e == 0))) begin
            for (int p = NUM_WR - 1; p >= 0; p--) begin
               if (wr_en[p] && (`RF_SLICE(wr_addr, p, ADDR_W) == ADDR_W'(e))) begin
                  wr_stb[e] = 1'b1;
                  wr_win[e] = `RF_SLICE(wr_data, p, DATA_W);
               end
            end
         end
      end
   end

   // Any pair of enabled ports aimed at the same legal entry is a collision.
   always_comb begin
      collision = 1'b0;
      for (int p = 0; p < NUM_WR; p++) begin
         for (int q = p + 1; q < NUM_WR; q++) begin
            if (wr_en[p] && wr_en[q] &&
                (`RF_SLICE(wr_addr, p, ADDR_W) == `RF_SLICE(wr_addr, q, ADDR_W)) &&
                legal(`RF_SLICE(wr_addr, p, ADDR_W)))
               collision = 1'b1;
         end
      end
   end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: storage, registered reads with valid, collision flag.
// Optional feature macro: REGFILE_BYPASS_EN -- a read hitting a same-edge write
// returns the winning write data instead of the old contents.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int DEPTH    = DEF_DEPTH,
   parameter int NUM_RD   = DEF_NUM_RD,
   parameter int NUM_WR   = DEF_NUM_WR,
   parameter int ZERO_REG = 0
) (
   input  logic         clk,
   input  logic         rst_n,
   regfile_mp_if.slave  bus
);

   localparam int ADDR_W = clog2(DEPTH);

   logic [DEPTH-1:0][DATA_W-1:0]  mem_q, mem_d;
   logic [NUM_RD-1:0][DATA_W-1:0] rd_data_q, rd_data_d;
   logic [NUM_RD-1:0]             rd_valid_q, rd_valid_d;
   logic                          wr_collision_q, wr_collision_d;

   logic [DEPTH-1:0]              wr_stb;
   logic [DEPTH-1:0][DATA_W-1:0]  wr_win;
   logic                          wr_col;
   logic [ADDR_W-1:0]             ra;

   regfile_wr_sel #(
      .DATA_W   (DATA_W),
      .DEPTH    (DEPTH),
      .ADDR_W   (ADDR_W),
      .NUM_WR   (NUM_WR),
      .ZERO_REG (ZERO_REG)
   ) u_wr_sel (
      .wr_en     (bus.wr_en),
      .wr_addr   (bus.wr_addr),
      .wr_data   (bus.wr_data),
      .wr_stb    (wr_stb),
      .wr_win    (wr_win),
      .collision (wr_col)
   );

   // Next storage contents: every strobed entry takes its winning data.
   always_comb begin
      mem_d = mem_q;
      for (int e = 0; e < DEPTH; e++) begin
         if (wr_stb[e]) mem_d[e] = wr_win[e];
      end
   end

   // Read capture: enabled ports load new data, idle ports hold their last value.
   always_comb begin
      ra             = '0;
      rd_valid_d     = bus.rd_en;
      rd_data_d      = rd_data_q;
      wr_collision_d = wr_col;
      for (int i = 0; i < NUM_RD; i++) begin
         ra = `RF_SLICE(bus.rd_addr, i, ADDR_W);
         if (bus.rd_en[i]) begin
            if ((int'(ra) >= DEPTH) || ((ZERO_REG != 0) && (ra == '0)))
               rd_data_d[i] = '0;
`ifdef REGFILE_BYPASS_EN
            else if (wr_stb[ra])
               rd_data_d[i] = wr_win[ra];
`endif
            else
               rd_data_d[i] = mem_q[ra];
         end
      end
   end

   // State update; reset wins over every enable presented in the same cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mem_q          <= '0;
         rd_data_q      <= '0;
         rd_valid_q     <= '0;
         wr_collision_q <= 1'b0;
      end else begin
         mem_q          <= mem_d;
         rd_data_q      <= rd_data_d;
         rd_valid_q     <= rd_valid_d;
         wr_collision_q <= wr_collision_d;
      end
   end

   assign bus.rd_data      = rd_data_q;
   assign bus.rd_valid     = rd_valid_q;
   assign bus.wr_collision = wr_collision_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: two instances (DEPTH=32 plain, DEPTH=20 ZERO_REG)
// share one stimulus stream; a reference model pushes expectations, a monitor checks.
module tb_regfile_mp;
   import regfile_pkg::*;

   localparam int DW = 64, NR = 4, NW = 2, AW = 5;
   localparam int DEP0 = 32, DEP1 = 20;
`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst_n;
   logic [NR-1:0]     rd_en;
   logic [NR*AW-1:0]  rd_addr;
   logic [NW-1:0]     wr_en;
   logic [NW*AW-1:0]  wr_addr;
   logic [NW*DW-1:0]  wr_data;

   regfile_mp_if #(.DATA_W(DW), .DEPTH(DEP0), .NUM_RD(NR), .NUM_WR(NW)) if0 ();
   regfile_mp_if #(.DATA_W(DW), .DEPTH(DEP1), .NUM_RD(NR), .NUM_WR(NW)) if1 ();

   assign if0.rd_en = rd_en;  assign if0.rd_addr = rd_addr;
   assign if0.wr_en = wr_en;  assign if0.wr_addr = wr_addr;  assign if0.wr_data = wr_data;
   assign if1.rd_en = rd_en;  assign if1.rd_addr = rd_addr;
   assign if1.wr_en = wr_en;  assign if1.wr_addr = wr_addr;  assign if1.wr_data = wr_data;

   regfile_mp #(.DATA_W(DW), .DEPTH(DEP0), .NUM_RD(NR), .NUM_WR(NW), .ZERO_REG(0))
      dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
   regfile_mp #(.DATA_W(DW), .DEPTH(DEP1), .NUM_RD(NR), .NUM_WR(NW), .ZERO_REG(1))
      dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

   typedef struct packed {
      logic [NR-1:0]         vld;
      logic [NR-1:0][DW-1:0] dat;
      logic                  coll;
   } exp_t;
   typedef struct packed { exp_t e1; exp_t e0; } pair_t;

   pair_t                 sbq[$];
   logic [DW-1:0]         m  [2][32];
   logic [NR-1:0][DW-1:0] rq [2];
   int checks = 0, errors = 0;

   // Reference model of one instance for the edge about to happen.
   task automatic model(input int d, output exp_t e);
      int            depth;
      bit            zr;
      logic [DW-1:0] nv [32];
      bit            hit [32];
      int            nwr [32];
      int            a;
      depth = (d == 0) ? DEP0 : DEP1;
      zr    = (d == 1);
      e     = '0;
      for (int k = 0; k < 32; k++) begin hit[k] = 0; nwr[k] = 0; nv[k] = '0; end
      if (!rst_n) begin
         for (int k = 0; k < 32; k++) m[d][k] = '0;
         rq[d] = '0;
         return;
      end
      // Lowest-index legal writer claims the entry; count writers for collisions.
      for (int p = 0; p < NW; p++) begin
         a = int'(wr_addr[p*AW +: AW]);
         if (wr_en[p] && a < depth && !(zr && a == 0)) begin
            nwr[a]++;
            if (!hit[a]) begin hit[a] = 1; nv[a] = wr_data[p*DW +: DW]; end
         end
      end
      for (int k = 0; k < 32; k++) if (nwr[k] >= 2) e.coll = 1'b1;
      for (int i = 0; i < NR; i++) begin
         a = int'(rd_addr[i*AW +: AW]);
         if (rd_en[i]) begin
            if (a >= depth || (zr && a == 0)) rq[d][i] = '0;
            else if (BYP && hit[a])           rq[d][i] = nv[a];
            else                              rq[d][i] = m[d][a];
         end
      end
      e.vld = rd_en;
      e.dat = rq[d];
      for (int k = 0; k < 32; k++) if (hit[k]) m[d][k] = nv[k];
   endtask

   task automatic step();
      pair_t pr;
      exp_t  e0, e1;
      model(0, e0);
      model(1, e1);
      pr.e0 = e0;
      pr.e1 = e1;
      sbq.push_back(pr);
      @(posedge clk);
      #2;
   endtask

   task automatic clr();
      rd_en = '0; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
   endtask

   task automatic wr(input int p, input int a, input logic [DW-1:0] v);
      wr_en[p] = 1'b1;
      wr_addr[p*AW +: AW] = AW'(a);
      wr_data[p*DW +: DW] = v;
   endtask

   task automatic rd(input int i, input int a);
      rd_en[i] = 1'b1;
      rd_addr[i*AW +: AW] = AW'(a);
   endtask

   task automatic chk(input int d, input exp_t e, input logic [NR-1:0] v,
                      input logic [NR*DW-1:0] dat, input logic c);
      checks++;
      if (v !== e.vld) begin
         errors++;
         $display("FAIL dut%0d rd_valid got %h exp %h t=%0t", d, v, e.vld, $time);
      end
      checks++;
      if (dat !== e.dat) begin
         errors++;
         $display("FAIL dut%0d rd_data got %h exp %h t=%0t", d, dat, e.dat, $time);
      end
      checks++;
      if (c !== e.coll) begin
         errors++;
         $display("FAIL dut%0d wr_collision got %b exp %b t=%0t", d, c, e.coll, $time);
      end
   endtask

   // Monitor: outputs are presented every cycle; compare 1 time unit after each edge.
   initial begin
      pair_t pr;
      forever begin
         @(posedge clk);
         #1;
         if (sbq.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard underflow t=%0t", $time);
         end else begin
            pr = sbq.pop_front();
            chk(0, pr.e0, if0.rd_valid, if0.rd_data, if0.wr_collision);
            chk(1, pr.e1, if1.rd_valid, if1.rd_data, if1.wr_collision);
         end
      end
   end

   initial begin
      int a;
      rst_n = 1'b0;
      clr();
      // Reset, then sweep every entry.
      step(); step();
      rst_n = 1'b1;
      for (int k = 0; k < 8; k++) begin
         clr();
         for (int i = 0; i < NR; i++) rd(i, k*4 + i);
         step();
      end
      clr(); step();
      // Concurrent writes, then multi-port reads of the same addresses.
      wr(0, 3, 64'hA5A5); wr(1, 7, 64'h1234); step();
      clr(); rd(0, 3); rd(1, 7); rd(2, 3); rd(3, 7); step();
      clr(); step();
      // Collision: port 0 wins.
      clr(); wr(0, 5, 64'h11); wr(1, 5, 64'h22); step();
      clr(); rd(0, 5); step();
      // Read and write of the same entry on one edge.
      clr(); wr(0, 9, 64'hFF); step();
      clr(); wr(1, 9, 64'h77); rd(0, 9); step();
      clr(); rd(0, 9); step();
      // Zero entry and out-of-range addresses.
      clr(); wr(0, 0, 64'hDEAD); wr(1, 25, 64'hBEEF); step();
      clr(); rd(0, 0); rd(1, 25); rd(2, 19); rd(3, 31); step();
      clr(); wr(0, 25, 64'h1); wr(1, 25, 64'h2); step();
      clr(); wr(0, 0, 64'h3); wr(1, 0, 64'h4); rd(0, 0); step();
      clr(); wr(0, 19, 64'h5); wr(1, 19, 64'h6); rd(1, 19); step();
      // Reset in the middle of traffic.
      clr(); wr(0, 4, 64'hCAFE); wr(1, 6, 64'hF00D);
      for (int i = 0; i < NR; i++) rd(i, i + 3);
      rst_n = 1'b0; step();
      rst_n = 1'b1; clr(); rd(0, 4); rd(1, 6); rd(2, 5); rd(3, 9); step();
      // Random traffic with occasional resets and clustered addresses.
      for (int n = 0; n < 400; n++) begin
         clr();
         rst_n = ($urandom_range(0, 49) != 0);
         rd_en = NR'($urandom);
         wr_en = NW'($urandom);
         for (int i = 0; i < NR; i++) begin
            a = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 3) : $urandom_range(0, 31);
            rd_addr[i*AW +: AW] = AW'(a);
         end
         for (int p = 0; p < NW; p++) begin
            a = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 3) : $urandom_range(0, 31);
            wr_addr[p*AW +: AW] = AW'(a);
            wr_data[p*DW +: DW] = {$urandom, $urandom};
         end
         step();
      end
      clr(); step();
      checks++;
      if (sbq.size() != 0) begin
         errors++;
         $display("FAIL scoreboard leftover got %0d exp 0", sbq.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
